// File: rtl/fb_pixel_writer.sv
// Pixel FIFO + frame-buffer writer: converts {x,y} to a linear 640x480 address.
// Optional FB_CLIP_EN: off-screen pixels retire without a memory write.
module fb_pixel_writer #(
    parameter int          DEPTH   = 8,
    parameter int          COLOR_W = 8,
    parameter logic [18:0] FB_BASE = 19'd0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_pix_valid,
    input  logic [18:0]        i_pix_addr,
    input  logic [COLOR_W-1:0] i_pix_color,
    input  logic               i_pix_last,
    output logic               o_stop,
    output logic               o_mem_req,
    output logic [18:0]        o_mem_addr,
    output logic [COLOR_W-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    output logic               o_busy,
    output logic               o_prim_done,
    output logic               o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_STOP = (AW+1)'(DEPTH - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [18:0]        r_q_addr  [DEPTH];
    logic [COLOR_W-1:0] r_q_color [DEPTH];
    logic               r_q_last  [DEPTH];
    logic               r_q_skip  [DEPTH];

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overflow;
    logic [0:0]         r_state;
    logic [18:0]        r_mem_addr;
    logic [COLOR_W-1:0] r_mem_wdata;
    logic               r_last;
    logic               r_skip_done;

    logic [18:0] w_x;
    logic [18:0] w_y;
    logic [18:0] w_lin;
    logic        w_skip;
    logic        w_empty;
    logic        w_full;
    logic        w_ack;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_h_skip;
    logic        w_h_last;

    // y*640 = (y<<9) + (y<<7); the sum wraps naturally at 19 bits
    assign w_x   = {9'd0, i_pix_addr[18:9]};
    assign w_y   = {10'd0, i_pix_addr[8:0]};
    assign w_lin = FB_BASE + (w_y << 9) + (w_y << 7) + w_x;

`ifdef FB_CLIP_EN
    assign w_skip = (i_pix_addr[18:9] >= 10'd640) || (i_pix_addr[8:0] >= 9'd480);
`else
    assign w_skip = 1'b0;
`endif

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == L_FULL);
    assign w_ack    = (r_state == ST_REQ) && i_mem_ack;
    assign w_pop    = !w_empty && ((r_state == ST_IDLE) || w_ack);
    assign w_push   = i_pix_valid && (!w_full || w_pop);
    assign w_drop   = i_pix_valid && w_full && !w_pop;
    assign w_h_skip = r_q_skip[r_rd_ptr];
    assign w_h_last = r_q_last[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= w_lin;
            r_q_color[r_wr_ptr] <= i_pix_color;
            r_q_last[r_wr_ptr]  <= i_pix_last;
            r_q_skip[r_wr_ptr]  <= w_skip;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Skipped entries retire one cycle after their pop, never colliding with an ack
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_last      <= 1'b0;
            r_skip_done <= 1'b0;
        end else begin
            r_skip_done <= w_pop && w_h_skip && w_h_last;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pop && !w_h_skip) begin
                        r_state     <= ST_REQ;
                        r_mem_addr  <= r_q_addr[r_rd_ptr];
                        r_mem_wdata <= r_q_color[r_rd_ptr];
                        r_last      <= w_h_last;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        if (w_pop && !w_h_skip) begin
                            r_mem_addr  <= r_q_addr[r_rd_ptr];
                            r_mem_wdata <= r_q_color[r_rd_ptr];
                            r_last      <= w_h_last;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_stop      = (r_count >= L_STOP);
    assign o_mem_req   = (r_state == ST_REQ);
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = !w_empty || (r_state == ST_REQ);
    assign o_prim_done = (w_ack && r_last) || r_skip_done;
    assign o_overflow  = r_overflow;

endmodule
